// File: rtl/vga_frame_engine.sv
// vga_frame_engine: parametrised VGA timing generator with a single sprite
// whose position is advanced once per frame in wrap or bounce mode.
module vga_frame_engine #(
   parameter int   CLK_DIV  = 4,
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_TOTAL  = 800,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_TOTAL  = 525,
   parameter logic SYNC_POL = 1'b0,
   parameter int   SPR_W    = 40,
   parameter int   SPR_H    = 40,
   parameter int   X0       = 300,
   parameter int   Y0       = 220,
   parameter int   VEL_W    = 5
) (
   input  logic             CLK100MHZ,
   input  logic             reset,
   input  logic [VEL_W-1:0] vel_x,
   input  logic [VEL_W-1:0] vel_y,
   input  logic             mode,
   output logic             HS,
   output logic             VS,
   output logic             blank,
   output logic [10:0]      hcount,
   output logic [10:0]      vcount,
   output logic             sprite_on,
   output logic             frame_tick,
   output logic [10:0]      sprite_x,
   output logic [10:0]      sprite_y
);

   localparam int DW = $clog2(CLK_DIV);
   localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);

   localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
   localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
   localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
   localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [10:0] X_RST  = 11'(X0);
   localparam logic [10:0] Y_RST  = 11'(Y0);

   localparam logic [11:0]        SPR_W12 = 12'(SPR_W);
   localparam logic [11:0]        SPR_H12 = 12'(SPR_H);
   localparam logic signed [11:0] X_LIM   = 12'(H_ACTIVE);
   localparam logic signed [11:0] Y_LIM   = 12'(V_ACTIVE);
   localparam logic signed [11:0] X_MAX   = 12'(H_ACTIVE - SPR_W);
   localparam logic signed [11:0] Y_MAX   = 12'(V_ACTIVE - SPR_H);

   // Next position and direction of one axis.
   typedef struct packed {
      logic        dir;
      logic [10:0] pos;
   } axis_t;

   // One frame step of one axis: add the (direction-adjusted) velocity, then
   // either wrap modulo lim or clamp to [0, top] and reverse direction.
   function automatic axis_t step_axis(
      input logic [10:0]        pos,
      input logic [VEL_W-1:0]   vel,
      input logic               dir,
      input logic               bounce,
      input logic signed [11:0] lim,
      input logic signed [11:0] top
   );
      logic signed [11:0] ev;
      logic signed [11:0] nx;
      axis_t              r;
      ev = {{(12 - VEL_W){vel[VEL_W-1]}}, vel};
      if (dir)
         ev = -ev;
      nx    = $signed({1'b0, pos}) + ev;
      r.dir = dir;
      r.pos = nx[10:0];
      if (!bounce) begin
         if (nx[11])
            r.pos = 11'(nx + lim);
         else if (nx >= lim)
            r.pos = 11'(nx - lim);
      end else begin
         if (nx[11]) begin
            r.pos = '0;
            r.dir = ~dir;
         end else if (nx > top) begin
            r.pos = top[10:0];
            r.dir = ~dir;
         end
      end
      return r;
   endfunction

   logic [DW-1:0] dcnt;
   logic [10:0]   hc;
   logic [10:0]   vc;
   logic          dir_x;
   logic          dir_y;
   logic          pix_ce;
   logic          frame_pt;
   logic          active;
   logic          spr_hit;
   axis_t         nxt_x;
   axis_t         nxt_y;

   // Pixel enable, area/sprite decodes of the current counters, next sprite position.
   // NOTE: every signal here is assigned on every pass, so no latch can be inferred.
   always_comb begin
      pix_ce   = (dcnt == D_LAST);
      frame_pt = (hc == '0) && (vc == V_ACT);
      active   = (hc < H_ACT) && (vc < V_ACT);
      spr_hit  = ({1'b0, hc} >= {1'b0, sprite_x}) && ({1'b0, hc} < {1'b0, sprite_x} + SPR_W12) &&
                 ({1'b0, vc} >= {1'b0, sprite_y}) && ({1'b0, vc} < {1'b0, sprite_y} + SPR_H12);
      nxt_x    = step_axis(sprite_x, vel_x, dir_x, mode, X_LIM, X_MAX);
      nxt_y    = step_axis(sprite_y, vel_y, dir_y, mode, Y_LIM, Y_MAX);
   end

   // Board-clock divider producing one pix_ce every CLK_DIV cycles.
   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK100MHZ) begin
      if (reset)
         dcnt <= '0;
      else if (pix_ce)
         dcnt <= '0;
      else
         dcnt <= dcnt + DW'(1);
   end

   // Horizontal and vertical pixel counters with terminal count TOTAL-1.
   always_ff @(posedge CLK100MHZ) begin
      if (reset) begin
         hc <= '0;
         vc <= '0;
      end else if (pix_ce) begin
         if (hc == H_LAST) begin
            hc <= '0;
            vc <= (vc == V_LAST) ? 11'd0 : vc + 11'd1;
         end else begin
            hc <= hc + 11'd1;
         end
      end
   end

   // Registered decodes, delayed together with hcount/vcount by one pixel.
   always_ff @(posedge CLK100MHZ) begin
      if (reset) begin
         hcount    <= '0;
         vcount    <= '0;
         HS        <= ~SYNC_POL;
         VS        <= ~SYNC_POL;
         blank     <= 1'b1;
         sprite_on <= 1'b0;
      end else if (pix_ce) begin
         hcount    <= hc;
         vcount    <= vc;
         HS        <= (hc >= HS_BEG && hc < HS_END) ? SYNC_POL : ~SYNC_POL;
         VS        <= (vc >= VS_BEG && vc < VS_END) ? SYNC_POL : ~SYNC_POL;
         blank     <= ~active;
         sprite_on <= active & spr_hit;
      end
   end

   // Sprite motion, applied once per frame at the start of vertical blank.
   always_ff @(posedge CLK100MHZ) begin
      if (reset) begin
         sprite_x   <= X_RST;
         sprite_y   <= Y_RST;
         dir_x      <= 1'b0;
         dir_y      <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= pix_ce & frame_pt;
         if (pix_ce && frame_pt) begin
            sprite_x <= nxt_x.pos;
            dir_x    <= nxt_x.dir;
            sprite_y <= nxt_y.pos;
            dir_y    <= nxt_y.dir;
         end
      end
   end

endmodule

// File: tb/tb_vga_frame_engine.sv
// tb_vga_frame_engine: small-raster build of vga_frame_engine checked every
// cycle against a time-based model, plus directed literal expectations.
module tb_vga_frame_engine;

   localparam int CLK_DIV  = 2;
   localparam int H_ACTIVE = 16;
   localparam int H_FP     = 2;
   localparam int H_SYNC   = 3;
   localparam int H_TOTAL  = 24;
   localparam int V_ACTIVE = 12;
   localparam int V_FP     = 1;
   localparam int V_SYNC   = 2;
   localparam int V_TOTAL  = 16;
   localparam bit SYNC_POL = 1'b1;
   localparam int SPR_W    = 4;
   localparam int SPR_H    = 3;
   localparam int X0       = 5;
   localparam int Y0       = 4;
   localparam int VEL_W    = 5;
   localparam int FRAME_CLKS = H_TOTAL * V_TOTAL * CLK_DIV;

   logic                    clk = 1'b0;
   logic                    reset;
   logic signed [VEL_W-1:0] vel_x;
   logic signed [VEL_W-1:0] vel_y;
   logic                    mode;
   logic                    HS, VS, blank, sprite_on, frame_tick;
   logic [10:0]             hcount, vcount, sprite_x, sprite_y;

   int n_checks = 0;
   int n_err    = 0;

   vga_frame_engine #(
      .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_TOTAL(H_TOTAL),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_TOTAL(V_TOTAL), .SYNC_POL(SYNC_POL),
      .SPR_W(SPR_W), .SPR_H(SPR_H), .X0(X0), .Y0(Y0), .VEL_W(VEL_W)
   ) dut (
      .CLK100MHZ (clk),
      .reset     (reset),
      .vel_x     (vel_x),
      .vel_y     (vel_y),
      .mode      (mode),
      .HS        (HS),
      .VS        (VS),
      .blank     (blank),
      .hcount    (hcount),
      .vcount    (vcount),
      .sprite_on (sprite_on),
      .frame_tick(frame_tick),
      .sprite_x  (sprite_x),
      .sprite_y  (sprite_y)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Plain-arithmetic motion rule for one axis.
   task automatic axis_step(input int p, input bit d, input int v, input bit bounce,
                            input int lim, input int top, output int np, output bit nd);
      int c;
      c  = p + (d ? -v : v);
      np = c;
      nd = d;
      if (!bounce) begin
         if (c < 0)         np = c + lim;
         else if (c >= lim) np = c - lim;
      end else begin
         if (c < 0)        begin np = 0;   nd = !d; end
         else if (c > top) begin np = top; nd = !d; end
      end
   endtask

   // ---------------- model + per-cycle compare ----------------
   // Outputs are derived from the number of clock edges since reset release:
   // after n pixel enables the outputs describe raster pixel n-1.
   bit m_valid = 1'b0;
   int m_t, m_x, m_y;
   bit m_dx, m_dy;
   bit e_hs, e_vs, e_blank, e_son, e_tick;
   int e_hc, e_vc;

   always @(posedge clk) begin : model
      bit r, md, ndx, ndy;
      int vx, vy, n, q, qh, qv, nx, ny;
      r  = reset;
      md = mode;
      vx = int'(vel_x);
      vy = int'(vel_y);
      #1;
      if (r) begin
         m_valid = 1'b1;
         m_t = 0; m_x = X0; m_y = Y0; m_dx = 1'b0; m_dy = 1'b0;
         e_hs = !SYNC_POL; e_vs = !SYNC_POL; e_blank = 1'b1; e_son = 1'b0; e_tick = 1'b0;
         e_hc = 0; e_vc = 0;
      end else if (m_valid) begin
         m_t++;
         e_tick = 1'b0;
         if (m_t % CLK_DIV == 0) begin
            n  = m_t / CLK_DIV;
            q  = (n - 1) % (H_TOTAL * V_TOTAL);
            qh = q % H_TOTAL;
            qv = q / H_TOTAL;
            e_hc    = qh;
            e_vc    = qv;
            e_hs    = (qh >= H_ACTIVE + H_FP && qh < H_ACTIVE + H_FP + H_SYNC) ? SYNC_POL : !SYNC_POL;
            e_vs    = (qv >= V_ACTIVE + V_FP && qv < V_ACTIVE + V_FP + V_SYNC) ? SYNC_POL : !SYNC_POL;
            e_blank = !(qh < H_ACTIVE && qv < V_ACTIVE);
            e_son   = !e_blank && qh >= m_x && qh < m_x + SPR_W && qv >= m_y && qv < m_y + SPR_H;
            if (qh == 0 && qv == V_ACTIVE) begin
               axis_step(m_x, m_dx, vx, md, H_ACTIVE, H_ACTIVE - SPR_W, nx, ndx);
               axis_step(m_y, m_dy, vy, md, V_ACTIVE, V_ACTIVE - SPR_H, ny, ndy);
               m_x = nx; m_dx = ndx; m_y = ny; m_dy = ndy;
               e_tick = 1'b1;
            end
         end
      end
      if (m_valid)
         check("pixel_outputs",
               {HS, VS, blank, sprite_on, frame_tick, hcount, vcount, sprite_x, sprite_y},
               {e_hs, e_vs, e_blank, e_son, e_tick, 11'(e_hc), 11'(e_vc), 11'(m_x), 11'(m_y)});
   end

   // ---------------- per-frame statistics (tick to tick) ----------------
   int cyc = 0;
   int c_son, c_hmin, c_hmax, c_act, c_hs, c_hsmin, c_hsmax, c_vs, c_vsmin, c_vsmax;
   int l_son, l_hmin, l_hmax, l_act, l_hs, l_hsmin, l_hsmax, l_vs, l_vsmin, l_vsmax;
   int line_stamp, line_period, tick_stamp, frame_period, n_ticks;
   bit prev_hs_act;

   task automatic clear_acc();
      c_son = 0; c_hmin = 9999; c_hmax = -1; c_act = 0;
      c_hs = 0; c_hsmin = 9999; c_hsmax = -1;
      c_vs = 0; c_vsmin = 9999; c_vsmax = -1;
   endtask

   always @(posedge clk) begin : monitor
      #1;
      cyc++;
      if (reset) begin
         clear_acc();
         line_stamp = -1; tick_stamp = -1; line_period = 0; frame_period = 0;
         n_ticks = 0; prev_hs_act = 1'b0;
      end else begin
         if (sprite_on) begin
            c_son++;
            if (int'(hcount) < c_hmin) c_hmin = int'(hcount);
            if (int'(hcount) > c_hmax) c_hmax = int'(hcount);
         end
         if (!blank) c_act++;
         if (HS == SYNC_POL) begin
            c_hs++;
            if (int'(hcount) < c_hsmin) c_hsmin = int'(hcount);
            if (int'(hcount) > c_hsmax) c_hsmax = int'(hcount);
            if (!prev_hs_act) begin
               if (line_stamp >= 0) line_period = cyc - line_stamp;
               line_stamp = cyc;
            end
         end
         prev_hs_act = (HS == SYNC_POL);
         if (VS == SYNC_POL) begin
            c_vs++;
            if (int'(vcount) < c_vsmin) c_vsmin = int'(vcount);
            if (int'(vcount) > c_vsmax) c_vsmax = int'(vcount);
         end
         if (frame_tick) begin
            l_son = c_son; l_hmin = c_hmin; l_hmax = c_hmax; l_act = c_act;
            l_hs = c_hs; l_hsmin = c_hsmin; l_hsmax = c_hsmax;
            l_vs = c_vs; l_vsmin = c_vsmin; l_vsmax = c_vsmax;
            clear_acc();
            n_ticks++;
            if (tick_stamp >= 0) frame_period = cyc - tick_stamp;
            tick_stamp = cyc;
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic do_reset(input int k);
      reset = 1'b1;
      repeat (k) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_ticks(input int k);
      int seen   = 0;
      int budget = (k + 2) * FRAME_CLKS;
      while (seen < k && budget > 0) begin
         @(posedge clk);
         #2;
         if (frame_tick) seen++;
         budget--;
      end
      if (seen < k) check("frame_tick_timeout", seen, k);
      @(negedge clk);
   endtask

   initial begin
      int guard;
      int cnt;
      reset = 1'b1; vel_x = '0; vel_y = '0; mode = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state (SYNC_POL=1, so inactive sync is 0).
      check("rst_hs", HS, 0);
      check("rst_vs", VS, 0);
      check("rst_blank", blank, 1);
      check("rst_hcount", hcount, 0);
      check("rst_sprite_on", sprite_on, 0);
      check("rst_frame_tick", frame_tick, 0);
      check("rst_sprite_x", sprite_x, 5);
      check("rst_sprite_y", sprite_y, 4);

      // Raster timing at rest.
      reset = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      check("first_pixel_hcount", hcount, 1);
      wait_ticks(2);
      check("hs_first_col", l_hsmin, 18);
      check("hs_last_col", l_hsmax, 20);
      check("hs_cycles", l_hs, 96);
      check("vs_first_line", l_vsmin, 13);
      check("vs_last_line", l_vsmax, 14);
      check("vs_cycles", l_vs, 96);
      check("active_cycles", l_act, 384);
      check("line_period", line_period, 48);
      check("frame_period", frame_period, 768);
      check("rest_sprite_cycles", l_son, 24);
      check("rest_sprite_hmin", l_hmin, 5);
      check("rest_sprite_hmax", l_hmax, 8);

      // Wrap mode, +3/-2 for 10 frames.
      vel_x = 5'sd3; vel_y = -5'sd2; mode = 1'b0;
      do_reset(2);
      wait_ticks(10);
      check("wrap10_x", sprite_x, 3);
      check("wrap10_y", sprite_y, 8);
      check("wrap10_ticks", n_ticks, 10);
      check("wrap10_clipped_cycles", l_son, 16);

      // Wrap across the left edge: 5 - 7 -> 14, only columns 14..15 drawn.
      vel_x = -5'sd7; vel_y = 5'sd0; mode = 1'b0;
      do_reset(2);
      wait_ticks(1);
      check("wrapneg_x", sprite_x, 14);
      check("wrapneg_y", sprite_y, 4);
      wait_ticks(1);
      check("wrapneg_cycles", l_son, 12);
      check("wrapneg_hmin", l_hmin, 14);
      check("wrapneg_hmax", l_hmax, 15);
      check("wrapneg_next_x", sprite_x, 7);

      // Bounce: x 5->10->12(clamp)->7, y 4->9(exact, no toggle)->9(clamp)->4.
      vel_x = 5'sd5; vel_y = 5'sd5; mode = 1'b1;
      do_reset(2);
      wait_ticks(1);
      check("bounce1_x", sprite_x, 10);
      check("bounce1_y", sprite_y, 9);
      wait_ticks(1);
      check("bounce2_x", sprite_x, 12);
      check("bounce2_y", sprite_y, 9);
      wait_ticks(1);
      check("bounce3_x", sprite_x, 7);
      check("bounce3_y", sprite_y, 4);

      // Mode switch with persisting direction: dir_x is reversed, so -7 moves right.
      vel_x = -5'sd7; vel_y = 5'sd0; mode = 1'b0;
      wait_ticks(1);
      check("switch_wrap_x", sprite_x, 14);
      vel_x = -5'sd1; mode = 1'b1;
      wait_ticks(1);
      check("switch_clamp_x", sprite_x, 12);
      wait_ticks(1);
      check("switch_after_x", sprite_x, 11);

      // Reset mid active area; dir_y must be cleared (stale dir would move y to 2).
      vel_x = 5'sd0; vel_y = 5'sd2; mode = 1'b0;
      guard = 0;
      while (!(blank == 1'b0 && vcount > 11'd2) && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      check("midframe_active_found", blank, 0);
      do_reset(3);
      reset = 1'b1;
      check("mid_rst_hs", HS, 0);
      check("mid_rst_vs", VS, 0);
      check("mid_rst_blank", blank, 1);
      check("mid_rst_hcount", hcount, 0);
      check("mid_rst_vcount", vcount, 0);
      check("mid_rst_sprite_x", sprite_x, 5);
      check("mid_rst_sprite_y", sprite_y, 4);
      reset = 1'b0;
      cnt = 0;
      while (cnt < 2000) begin
         @(posedge clk);
         #2;
         cnt++;
         if (frame_tick) break;
      end
      check("tick_latency", cnt, 578);
      @(negedge clk);
      check("post_rst_y", sprite_y, 6);
      check("post_rst_x", sprite_x, 5);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
